mean_filter_pipe: RTL and testbench

//  Parametrised, pipelined neighbourhood mean filter for the cartoonifier datapath.
//  - Takes one KxK window of NUM_CH-channel pixels per handshake.
//  - Outputs the per-channel mean of the K*K-1 neighbours; the centre pixel is excluded.
//  - Edge-flagged pixels are replaced by a fixed colour.
//  - Sits between the window buffer and the frame writer; valid/ready flow control on both sides.

---
 rtl/mean_filter_pipe_if.sv | 30 +++
 rtl/mean_filter_pipe.sv | 131 +++++++++++++
 tb/tb_mean_filter_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mean_filter_pipe_if.sv
// Stream bundle between the window buffer, the mean filter and the frame writer.
// The slave view belongs to the filter; the master view drives it.
interface mean_filter_pipe_if #(
  parameter int K      = 3,
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3
);
  localparam int PIX_W = NUM_CH * CH_W;
  localparam int WIN_W = K * K * PIX_W;

  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] in_window;
  logic             in_edge;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sof;

  modport master (
    output in_valid, in_window, in_edge, in_sof, out_ready,
    input  in_ready, out_valid, out_pixel, out_sof
  );

  modport slave (
    input  in_valid, in_window, in_edge, in_sof, out_ready,
    output in_ready, out_valid, out_pixel, out_sof
  );
endinterface

// File: rtl/mean_filter_pipe.sv
// Three-stage neighbourhood mean filter: S1 sums the K*K-1 neighbours, S2 divides, S3 selects edge colour.
// Define MEAN_FILTER_BLEND_EN to average each output with the previous non-edge output.
module mean_filter_pipe #(
  parameter int          K        = 3,
  parameter int          CH_W     = 8,
  parameter int          NUM_CH   = 3,
  parameter int unsigned EDGE_VAL = 20
) (
  input logic            clk,
  input logic            n_rst,
  mean_filter_pipe_if.slave bus
);
  localparam int PIX_W  = NUM_CH * CH_W;
  localparam int N      = K * K - 1;
  localparam int CENTRE = (K * K - 1) / 2;
  localparam int LOG_N  = $clog2(N);
  localparam int SUM_W  = CH_W + LOG_N;
  localparam int SH     = SUM_W + LOG_N;
  localparam int PROD_W = SUM_W + SH;
  // Rounded-up reciprocal; the rounding error stays below one LSB of the quotient for every reachable sum.
  localparam longint unsigned RECIP = ((64'd1 << SH) + longint'(N) - 1) / longint'(N);
  localparam logic [CH_W-1:0] EDGE_CH = EDGE_VAL[CH_W-1:0];

  logic stall;
  logic adv;

  logic [0:NUM_CH-1][SUM_W-1:0] sum_d;
  logic [0:NUM_CH-1][SUM_W-1:0] s1_sum;
  logic                         s1_valid, s1_edge, s1_sof;

  logic [0:NUM_CH-1][CH_W-1:0]  mean_d;
  logic [0:NUM_CH-1][CH_W-1:0]  s2_mean;
  logic                         s2_valid, s2_edge, s2_sof;

  logic [0:NUM_CH-1][CH_W-1:0]  s3_d;
  logic [0:NUM_CH-1][CH_W-1:0]  out_pixel_q;
  logic                         out_valid_q, out_sof_q;

  // The whole pipe moves on one enable, so bubbles and flags stay aligned with their data.
  assign stall        = out_valid_q && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sof   = out_sof_q;

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < K * K; p++) begin
        if (p != CENTRE) begin
          sum_d[c] = sum_d[c] + SUM_W'(bus.in_window[(K*K-1-p)*PIX_W + (NUM_CH-1-c)*CH_W +: CH_W]);
        end
      end
    end
  end

  always_comb begin
    mean_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mean_d[c] = CH_W'((PROD_W'(s1_sum[c]) * PROD_W'(RECIP)) >> SH);
    end
  end

`ifdef MEAN_FILTER_BLEND_EN
  logic [0:NUM_CH-1][CH_W-1:0] hist;
  logic                        hist_valid;
`endif

  always_comb begin
    s3_d = s2_mean;
    if (s2_edge) begin
      s3_d = {NUM_CH{EDGE_CH}};
    end
`ifdef MEAN_FILTER_BLEND_EN
    else if (!s2_sof && hist_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s3_d[c] = (hist[c] >> 1) + (s2_mean[c] >> 1);
      end
    end
`endif
  end

  // NOTE: datapath registers are reset along with the valids so a reset leaves no stale pixel on out_pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid    <= 1'b0;
      s1_edge     <= 1'b0;
      s1_sof      <= 1'b0;
      s1_sum      <= '0;
      s2_valid    <= 1'b0;
      s2_edge     <= 1'b0;
      s2_sof      <= 1'b0;
      s2_mean     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_pixel_q <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum  <= sum_d;
        s1_edge <= bus.in_edge;
        s1_sof  <= bus.in_sof;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mean <= mean_d;
        s2_edge <= s1_edge;
        s2_sof  <= s1_sof;
      end
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_pixel_q <= s3_d;
        out_sof_q   <= s2_sof;
      end
    end
  end

`ifdef MEAN_FILTER_BLEND_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist       <= '0;
      hist_valid <= 1'b0;
    end else if (adv && s2_valid && !s2_edge) begin
      hist       <= s3_d;
      hist_valid <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mean_filter_pipe.sv
// Scoreboarded bench for mean_filter_pipe: K=3 instance under a queue-based monitor, K=5 instance for wide windows.
// Builds in either configuration; expectations follow MEAN_FILTER_BLEND_EN.
module tb_mean_filter_pipe;
  localparam int W3 = 9 * 24;
  localparam int W5 = 25 * 24;
  localparam logic [23:0] EDGE_PIX = 24'h141414;

  typedef struct packed {
    logic [23:0] pix;
    logic        sof;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  mean_filter_pipe_if #(.K(3), .CH_W(8), .NUM_CH(3)) bus3 ();
  mean_filter_pipe_if #(.K(5), .CH_W(8), .NUM_CH(3)) bus5 ();

  mean_filter_pipe #(.K(3), .CH_W(8), .NUM_CH(3), .EDGE_VAL(20)) u_dut3 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus3.slave)
  );

  mean_filter_pipe #(.K(5), .CH_W(8), .NUM_CH(3), .EDGE_VAL(20)) u_dut5 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus5.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t sb_head;
  logic [23:0] hist_m;
  bit          hist_v_m;

  function automatic logic [23:0] mean3(input logic [W3-1:0] w);
    logic [23:0] r;
    int s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int p = 0; p < 9; p++) begin
        if (p != 4) s += int'(w[(8-p)*24 + (2-c)*8 +: 8]);
      end
      r[(2-c)*8 +: 8] = 8'(s / 8);
    end
    return r;
  endfunction

  function automatic logic [W3-1:0] uni3(input logic [23:0] nb, input logic [23:0] ctr);
    logic [W3-1:0] w;
    for (int p = 0; p < 9; p++) w[(8-p)*24 +: 24] = (p == 4) ? ctr : nb;
    return w;
  endfunction

  function automatic logic [W3-1:0] rand_win3();
    logic [W3-1:0] w;
    for (int p = 0; p < 9; p++) w[(8-p)*24 +: 24] = 24'($urandom);
    return w;
  endfunction

  task automatic model_push(input logic [W3-1:0] w, input logic e, input logic sof);
    logic [23:0] pix;
    pix = e ? EDGE_PIX : mean3(w);
`ifdef MEAN_FILTER_BLEND_EN
    if (!e) begin
      if (!sof && hist_v_m) begin
        for (int c = 0; c < 3; c++) pix[c*8 +: 8] = (hist_m[c*8 +: 8] >> 1) + (pix[c*8 +: 8] >> 1);
      end
      hist_m   = pix;
      hist_v_m = 1'b1;
    end
`endif
    sb.push_back('{pix: pix, sof: sof});
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus3.out_valid === 1'b1 && bus3.out_ready === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected output %h sof=%b, none expected", bus3.out_pixel, bus3.out_sof);
      end else begin
        sb_head = sb.pop_front();
        if ({bus3.out_pixel, bus3.out_sof} !== sb_head) begin
          n_fail++;
          $display("FAIL scoreboard: got %h sof=%b, expected %h sof=%b",
                   bus3.out_pixel, bus3.out_sof, sb_head.pix, sb_head.sof);
        end
      end
    end
  end

  task automatic send3(input logic [W3-1:0] w, input logic e, input logic sof);
    bit done;
    done = 1'b0;
    bus3.in_window = w;
    bus3.in_edge   = e;
    bus3.in_sof    = sof;
    bus3.in_valid  = 1'b1;
    model_push(w, e, sof);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus3.in_ready;
      @(posedge clk);
    end
    #1 bus3.in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send3: in_ready never seen, got 0 required 1");
    end
  endtask

  task automatic wait_out3(output logic [23:0] pix, output bit ok);
    ok  = 1'b0;
    pix = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus3.out_valid && bus3.out_ready) begin
        pix = bus3.out_pixel;
        ok  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_window = '0; bus3.in_edge = 1'b0; bus3.in_sof = 1'b0; bus3.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_window = '0; bus5.in_edge = 1'b0; bus5.in_sof = 1'b0; bus5.out_ready = 1'b1;
    hist_v_m = 1'b0;
    hist_m   = '0;
    #12;
    n_checks += 4;
    if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus3.out_valid); end
    if (bus3.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus3.in_ready); end
    if (bus3.out_pixel !== 24'h0) begin n_fail++; $display("FAIL reset_out_pixel: got %h expected 0", bus3.out_pixel); end
    if (bus3.out_sof !== 1'b0) begin n_fail++; $display("FAIL reset_out_sof: got %b expected 0", bus3.out_sof); end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    send3(uni3({8'd80, 8'd160, 8'd240}, 24'hFFFFFF), 1'b0, 1'b1);
    n_checks++;
    if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c1: out_valid got %b expected 0", bus3.out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c2: out_valid got %b expected 0", bus3.out_valid); end
    @(posedge clk); #1;
    n_checks += 2;
    if (bus3.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_c3: out_valid got %b expected 1", bus3.out_valid); end
    if (bus3.out_pixel !== 24'h50A0F0) begin n_fail++; $display("FAIL latency_pix: got %h expected 50a0f0", bus3.out_pixel); end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp;
    logic [W3-1:0] w;
    logic [23:0]   pix;
    bit            ok;
    int            k;
    w = uni3({8'd0, 8'd0, 8'd255}, {8'd200, 8'd0, 8'd255});
    k = 0;
    for (int p = 0; p < 9; p++) begin
      if (p != 4) begin
        w[(8-p)*24 + 16 +: 8] = 8'(10 * (k + 1));
        k++;
      end
    end
    send3(w, 1'b0, 1'b1);
    wait_out3(pix, ok);
    n_checks++;
    if (!ok || pix !== {8'd45, 8'd0, 8'd255}) begin
      n_fail++;
      $display("FAIL ramp_mean: got %h (seen=%0d) expected 2d00ff", pix, ok);
    end
  endtask

  task automatic test_edge;
    logic [23:0] pix;
    bit          ok;
    send3(rand_win3(), 1'b1, 1'b1);
    wait_out3(pix, ok);
    n_checks++;
    if (!ok || pix !== EDGE_PIX) begin n_fail++; $display("FAIL edge_colour: got %h (seen=%0d) expected 141414", pix, ok); end
  endtask

  task automatic k5_run(input logic [W5-1:0] w, input logic [23:0] exp_pix, input string name);
    bit acc, ok;
    acc = 1'b0;
    ok  = 1'b0;
    bus5.in_window = w;
    bus5.in_edge   = 1'b0;
    bus5.in_sof    = 1'b1;
    bus5.in_valid  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus5.in_ready;
      @(posedge clk);
    end
    #1 bus5.in_valid = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus5.out_valid) begin
        ok = 1'b1;
        n_checks++;
        if (bus5.out_pixel !== exp_pix) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", name, bus5.out_pixel, exp_pix);
        end
      end
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL %s: no output, got out_valid 0 required 1", name); end
    @(posedge clk); #1;
  endtask

  task automatic test_k5;
    logic [W5-1:0] w;
    for (int p = 0; p < 25; p++) w[(24-p)*24 +: 24] = (p == 12) ? 24'h000000 : 24'hFFFFFF;
    k5_run(w, 24'hFFFFFF, "k5_all_255");
    w[24*24 +: 24] = 24'hFEFEFE;
    k5_run(w, 24'hFEFEFE, "k5_sum_6119");
  endtask

  task automatic test_stall;
    logic [W3-1:0] wd;
    bus3.out_ready = 1'b0;
    send3(rand_win3(), 1'b0, 1'b1);
    send3(rand_win3(), 1'b0, 1'b0);
    send3(rand_win3(), 1'b1, 1'b0);
    wd = rand_win3();
    bus3.in_window = wd;
    bus3.in_edge   = 1'b0;
    bus3.in_sof    = 1'b0;
    bus3.in_valid  = 1'b1;
    model_push(wd, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks += 3;
      if (bus3.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus3.out_valid); end
      if (bus3.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus3.in_ready); end
      if (bus3.out_pixel !== sb[0].pix) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, bus3.out_pixel, sb[0].pix); end
      @(posedge clk); #1;
    end
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus3.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume[%0d]: out_valid got %b expected 1", i, bus3.out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) send3(rand_win3(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
  endtask

  task automatic test_random_ready;
    fork
      begin
        for (int i = 0; i < 16; i++) send3(rand_win3(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          bus3.out_ready = 1'($urandom_range(0, 1));
        end
        bus3.out_ready = 1'b1;
      end
    join
    bus3.out_ready = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL %s: %0d outputs outstanding, expected 0", name, sb.size()); end
  endtask

  task automatic test_blend;
    logic [23:0] p1, p2;
    bit          ok1, ok2;
    logic [7:0]  exp_r2;
`ifdef MEAN_FILTER_BLEND_EN
    exp_r2 = 8'd75;
`else
    exp_r2 = 8'd50;
`endif
    send3(uni3({8'd100, 8'd40, 8'd60}, 24'hABCDEF), 1'b0, 1'b1);
    send3(uni3({8'd50, 8'd40, 8'd60}, 24'h123456), 1'b0, 1'b0);
    wait_out3(p1, ok1);
    wait_out3(p2, ok2);
    n_checks += 2;
    if (!ok1 || p1[23:16] !== 8'd100) begin n_fail++; $display("FAIL blend_first: R got %0d (seen=%0d) expected 100", p1[23:16], ok1); end
    if (!ok2 || p2[23:16] !== exp_r2) begin n_fail++; $display("FAIL blend_second: R got %0d (seen=%0d) expected %0d", p2[23:16], ok2, exp_r2); end
  endtask

  task automatic test_reset_mid;
    logic [W3-1:0] wd;
    logic [23:0]   pix;
    bit            ok;
    send3(rand_win3(), 1'b0, 1'b1);
    send3(rand_win3(), 1'b0, 1'b0);
    send3(rand_win3(), 1'b0, 1'b0);
    #1 n_rst = 1'b0;
    #1;
    sb.delete();
    hist_v_m = 1'b0;
    n_checks += 2;
    if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", bus3.out_valid); end
    if (bus3.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", bus3.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale[%0d]: out_valid got %b expected 0", i, bus3.out_valid); end
    end
    wd = rand_win3();
    send3(wd, 1'b0, 1'b0);
    wait_out3(pix, ok);
    n_checks++;
    if (!ok || pix !== mean3(wd)) begin n_fail++; $display("FAIL midreset_first: got %h (seen=%0d) expected %h", pix, ok, mean3(wd)); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ramp();
    test_edge();
    test_k5();
    test_stall();
    drain("stall_drain");
    test_back_to_back();
    drain("b2b_drain");
    test_random_ready();
    drain("random_drain");
    test_blend();
    test_reset_mid();
    drain("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
